// File: rtl/single_cycle_data_path_if.sv
// Memory-side bus of the single-cycle MIPS32 datapath: instruction fetch port and data load/store port.
interface single_cycle_data_path_if;
  // No valid/ready: both memories answer combinationally in the same cycle; the core holds
  // insMemRead high whenever out of reset, and dataMemRead/dataMemWrite are single-cycle
  // strobes qualified by dataMemAddress; a store commits in memory on the rising clock edge.
  logic [31:0] insReadValue;
  logic [31:0] dataReadValue;
  logic [31:0] insMemAddress;
  logic        insMemRead;
  logic [31:0] dataMemAddress;
  logic        dataMemRead;
  logic        dataMemWrite;
  logic [31:0] dataWriteValue;

  modport master (
    input  insReadValue, dataReadValue,
    output insMemAddress, insMemRead, dataMemAddress, dataMemRead, dataMemWrite, dataWriteValue
  );

  modport slave (
    output insReadValue, dataReadValue,
    input  insMemAddress, insMemRead, dataMemAddress, dataMemRead, dataMemWrite, dataWriteValue
  );
endinterface

// File: rtl/single_cycle_data_path.sv
// Single-cycle MIPS32 integer datapath (one instruction per clock, CPI 1).
// Define SINGLE_CYCLE_EXCEPTIONS_EN to enable overflow and reserved-instruction traps.
module single_cycle_data_path (
  input  logic                            clock,
  input  logic                            resetN,
  single_cycle_data_path_if.master        memBus
);
  localparam logic [31:0] TextBase  = 32'h0040_0000;
  localparam logic [31:0] SpInit    = 32'h1001_03FC;
  localparam logic [31:0] ExcVector = 32'h8000_0180;

  localparam logic [5:0] OpRType = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04,
                         OpBne = 6'h05, OpAddi = 6'h08, OpAddiu = 6'h09, OpSlti = 6'h0A,
                         OpSltiu = 6'h0B, OpAndi = 6'h0C, OpOri = 6'h0D, OpXori = 6'h0E,
                         OpLui = 6'h0F, OpLw = 6'h23, OpSw = 6'h2B;
  localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnSra = 6'h03, FnJr = 6'h08,
                         FnAdd = 6'h20, FnAddu = 6'h21, FnSub = 6'h22, FnSubu = 6'h23,
                         FnAnd = 6'h24, FnOr = 6'h25, FnXor = 6'h26, FnNor = 6'h27,
                         FnSlt = 6'h2A, FnSltu = 6'h2B;

`ifdef SINGLE_CYCLE_EXCEPTIONS_EN
  localparam bit ExcEnabled = 1'b1;
`else
  localparam bit ExcEnabled = 1'b0;
`endif

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSltu,
    AluSll, AluSrl, AluSra, AluLui
  } alu_kind_t;

  logic [31:0] pc, epc, cause;
  logic [3:0]  status;
  logic [31:0] regFile [32];

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shiftAmount;
  logic [15:0] immediate;
  logic [25:0] jumpAddress;

  assign instr       = memBus.insReadValue;
  assign opcode      = instr[31:26];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign shiftAmount = instr[10:6];
  assign funct       = instr[5:0];
  assign immediate   = instr[15:0];
  assign jumpAddress = instr[25:0];

  logic [31:0] rsValue, rtValue, signExt, zeroExt, opB, pcPlus4;
  assign rsValue = (rs == 5'd0) ? 32'h0 : regFile[rs];
  assign rtValue = (rt == 5'd0) ? 32'h0 : regFile[rt];
  assign signExt = {{16{immediate[15]}}, immediate};
  assign zeroExt = {16'h0, immediate};
  assign pcPlus4 = pc + 32'd4;

  alu_kind_t   aluKind;
  logic        isAluOp, trapsOvf, illegal, regWrite, isLoad, isStore;
  logic [4:0]  writeReg;

  always_comb begin
    aluKind  = AluAdd;
    opB      = signExt;
    isAluOp  = 1'b0;
    trapsOvf = 1'b0;
    illegal  = 1'b0;
    regWrite = 1'b0;
    isLoad   = 1'b0;
    isStore  = 1'b0;
    writeReg = rt;
    case (opcode)
      OpRType: begin
        opB      = rtValue;
        writeReg = rd;
        isAluOp  = 1'b1;
        regWrite = 1'b1;
        case (funct)
          FnAdd:  begin aluKind = AluAdd; trapsOvf = 1'b1; end
          FnAddu: aluKind = AluAdd;
          FnSub:  begin aluKind = AluSub; trapsOvf = 1'b1; end
          FnSubu: aluKind = AluSub;
          FnAnd:  aluKind = AluAnd;
          FnOr:   aluKind = AluOr;
          FnXor:  aluKind = AluXor;
          FnNor:  aluKind = AluNor;
          FnSlt:  aluKind = AluSlt;
          FnSltu: aluKind = AluSltu;
          FnSll:  aluKind = AluSll;
          FnSrl:  aluKind = AluSrl;
          FnSra:  aluKind = AluSra;
          FnJr:   begin isAluOp = 1'b0; regWrite = 1'b0; end
          default: begin isAluOp = 1'b0; regWrite = 1'b0; illegal = 1'b1; end
        endcase
      end
      OpAddi:  begin aluKind = AluAdd; trapsOvf = 1'b1; isAluOp = 1'b1; regWrite = 1'b1; end
      OpAddiu: begin aluKind = AluAdd;  isAluOp = 1'b1; regWrite = 1'b1; end
      OpSlti:  begin aluKind = AluSlt;  isAluOp = 1'b1; regWrite = 1'b1; end
      OpSltiu: begin aluKind = AluSltu; isAluOp = 1'b1; regWrite = 1'b1; end
      OpAndi:  begin aluKind = AluAnd; opB = zeroExt; isAluOp = 1'b1; regWrite = 1'b1; end
      OpOri:   begin aluKind = AluOr;  opB = zeroExt; isAluOp = 1'b1; regWrite = 1'b1; end
      OpXori:  begin aluKind = AluXor; opB = zeroExt; isAluOp = 1'b1; regWrite = 1'b1; end
      OpLui:   begin aluKind = AluLui;  isAluOp = 1'b1; regWrite = 1'b1; end
      OpLw:    begin isLoad = 1'b1; regWrite = 1'b1; end
      OpSw:    isStore = 1'b1;
      OpBeq, OpBne, OpJ: ;
      OpJal:   begin regWrite = 1'b1; writeReg = 5'd31; end
      default: illegal = 1'b1;
    endcase
  end

  // Subtraction is a + ~b + 1 so the carry-out reads directly as "no borrow".
  logic [32:0] sum33, diff33;
  logic [31:0] aluOut;
  logic        carry, ovf;
  assign sum33  = {1'b0, rsValue} + {1'b0, opB};
  assign diff33 = {1'b0, rsValue} + {1'b0, ~opB} + 33'd1;

  always_comb begin
    aluOut = 32'h0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (aluKind)
      AluAdd: begin
        aluOut = sum33[31:0];
        carry  = sum33[32];
        ovf    = (rsValue[31] == opB[31]) && (sum33[31] != rsValue[31]);
      end
      AluSub: begin
        aluOut = diff33[31:0];
        carry  = diff33[32];
        ovf    = (rsValue[31] != opB[31]) && (diff33[31] != rsValue[31]);
      end
      AluAnd:  aluOut = rsValue & opB;
      AluOr:   aluOut = rsValue | opB;
      AluXor:  aluOut = rsValue ^ opB;
      AluNor:  aluOut = ~(rsValue | opB);
      AluSlt:  aluOut = {31'b0, $signed(rsValue) < $signed(opB)};
      AluSltu: aluOut = {31'b0, rsValue < opB};
      AluSll:  aluOut = opB << shiftAmount;
      AluSrl:  aluOut = opB >> shiftAmount;
      AluSra:  aluOut = $unsigned($signed(opB) >>> shiftAmount);
      AluLui:  aluOut = {immediate, 16'h0};
      default: aluOut = 32'h0;
    endcase
  end

  logic [3:0]  nextStatus;
  logic [31:0] nextCause, nextPc, writeData;
  logic        ovfTrap, trapTaken, branchTaken;

  assign nextStatus  = {ovf, aluOut[31], aluOut == 32'h0, carry};
  assign ovfTrap     = trapsOvf && ovf;
  assign nextCause   = ovfTrap ? 32'h30 : 32'h28;
  assign trapTaken   = ExcEnabled && (ovfTrap || illegal);
  assign branchTaken = ((opcode == OpBeq) && (rsValue == rtValue)) ||
                       ((opcode == OpBne) && (rsValue != rtValue));
  assign writeData   = isLoad ? memBus.dataReadValue :
                       (opcode == OpJal) ? pcPlus4 : aluOut;

  always_comb begin
    if (trapTaken)                                   nextPc = ExcVector;
    else if (branchTaken)                            nextPc = pcPlus4 + (signExt << 2);
    else if ((opcode == OpJ) || (opcode == OpJal))   nextPc = {pcPlus4[31:28], jumpAddress, 2'b00};
    else if ((opcode == OpRType) && (funct == FnJr)) nextPc = rsValue;
    else                                             nextPc = pcPlus4;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc     <= TextBase;
      status <= 4'h0;
      epc    <= 32'h0;
      cause  <= 32'h0;
      for (int i = 0; i < 32; i++) regFile[i] <= (i == 29) ? SpInit : 32'h0;
    end else begin
      pc <= nextPc;
      if (trapTaken) begin
        epc   <= pc;
        cause <= nextCause;
      end else begin
        if (regWrite && (writeReg != 5'd0)) regFile[writeReg] <= writeData;
        if (isAluOp) status <= nextStatus;
      end
    end
  end

  assign memBus.insMemAddress  = pc;
  assign memBus.insMemRead     = resetN;
  assign memBus.dataMemAddress = aluOut;
  assign memBus.dataMemRead    = resetN && isLoad;
  assign memBus.dataMemWrite   = resetN && isStore && !trapTaken;
  assign memBus.dataWriteValue = rtValue;
endmodule

// File: tb/tb_single_cycle_data_path.sv
// Bench for single_cycle_data_path: directed program plus random programs, each instruction
// checked against an instruction-level reference model of the MIPS32 subset.
module tb_single_cycle_data_path;
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  single_cycle_data_path_if bus();
  single_cycle_data_path dut (.clock(clock), .resetN(resetN), .memBus(bus));

  // ---------------- environment memories ----------------
  logic [31:0] imem [512];
  logic [31:0] dmem [256];
  logic [31:0] iOff, dOff;

  always_comb begin
    iOff = bus.insMemAddress - TEXT_BASE;
    bus.insReadValue = (iOff < 32'd2048) ? imem[iOff[10:2]] : 32'h0;
  end

  always_comb begin
    dOff = bus.dataMemAddress - DATA_BASE;
    bus.dataReadValue = (dOff < 32'd1024) ? dmem[dOff[9:2]] : 32'h0;
  end

  always @(posedge clock) begin
    if (bus.dataMemWrite && (dOff < 32'd1024)) dmem[dOff[9:2]] <= bus.dataWriteValue;
  end

  // ---------------- checking ----------------
  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_epc, m_cause;
  logic [3:0]  m_status;
  logic [31:0] m_rf [32];
  logic [31:0] m_dmem [256];
  // Pending effects of the instruction currently at m_pc.
  logic [31:0] n_pc, n_val, n_cause, e_addr, e_wdata;
  logic [4:0]  n_dst;
  logic [3:0]  n_status;
  logic        n_wr, n_alu, n_exc, e_rd, e_wr;

  task automatic model_reset();
    m_pc = TEXT_BASE; m_epc = 0; m_cause = 0; m_status = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_rf[29] = 32'h1001_03FC;
  endtask

  function automatic logic [31:0] fetch(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - TEXT_BASE;
    return (off < 32'd2048) ? imem[off[10:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - DATA_BASE;
    return (off < 32'd1024) ? m_dmem[off[9:2]] : 32'h0;
  endfunction

  task automatic arith(input logic [31:0] x, input logic [31:0] y, input bit sub,
                       output logic [31:0] r, output logic c, output logic v);
    longint ux, uy, sx, sy, s;
    ux = longint'({32'h0, x}); uy = longint'({32'h0, y});
    sx = longint'($signed(x)); sy = longint'($signed(y));
    if (!sub) begin r = x + y; c = (ux + uy) > 64'hFFFF_FFFF; s = sx + sy; end
    else      begin r = x - y; c = (x >= y);                 s = sx - sy; end
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endtask

  task automatic model_exec(input logic [31:0] ins);
    logic [5:0] op, fn; logic [4:0] rs, rt, rd, sh; logic [15:0] imm;
    logic [31:0] a, b, simm, zimm, res; logic c, v; bit trap, bad;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6]; imm = ins[15:0];
    a = m_rf[rs]; b = m_rf[rt];
    simm = {{16{imm[15]}}, imm}; zimm = {16'h0, imm};
    res = 0; c = 0; v = 0; trap = 0; bad = 0;
    n_pc = m_pc + 4; n_wr = 0; n_alu = 0; n_exc = 0; n_dst = rt; n_cause = 0;
    e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0;
    case (op)
      6'h00: begin
        n_dst = rd; n_alu = 1;
        case (fn)
          6'h20, 6'h21: begin arith(a, b, 0, res, c, v); trap = (fn == 6'h20) && v; end
          6'h22, 6'h23: begin arith(a, b, 1, res, c, v); trap = (fn == 6'h22) && v; end
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: res = (a < b) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = $signed(b) >>> sh;
          6'h08: begin n_alu = 0; n_pc = a; end
          default: begin n_alu = 0; bad = 1; end
        endcase
        n_wr = n_alu;
      end
      6'h08, 6'h09: begin arith(a, simm, 0, res, c, v); trap = (op == 6'h08) && v; n_alu = 1; end
      6'h0A: begin res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; n_alu = 1; end
      6'h0B: begin res = (a < simm) ? 32'd1 : 32'd0; n_alu = 1; end
      6'h0C: begin res = a & zimm; n_alu = 1; end
      6'h0D: begin res = a | zimm; n_alu = 1; end
      6'h0E: begin res = a ^ zimm; n_alu = 1; end
      6'h0F: begin res = {imm, 16'h0}; n_alu = 1; end
      6'h23: begin e_rd = 1; e_addr = a + simm; res = m_load(e_addr); n_wr = 1; end
      6'h2B: begin e_wr = 1; e_addr = a + simm; e_wdata = b; end
      6'h04: if (a == b) n_pc = m_pc + 4 + (simm << 2);
      6'h05: if (a != b) n_pc = m_pc + 4 + (simm << 2);
      6'h02: n_pc = {n_pc[31:28], ins[25:0], 2'b00};
      6'h03: begin n_pc = {n_pc[31:28], ins[25:0], 2'b00}; n_wr = 1; n_dst = 5'd31; res = m_pc + 4; end
      default: bad = 1;
    endcase
    if (op != 6'h00 && n_alu) n_wr = 1;
    n_val = res;
    n_status = {v, res[31], res == 32'h0, c};
`ifdef SINGLE_CYCLE_EXCEPTIONS_EN
    if (trap || bad) begin
      n_exc = 1; n_cause = trap ? 32'h30 : 32'h28; n_pc = 32'h8000_0180;
      n_wr = 0; n_alu = 0; e_wr = 0;
    end
`endif
  endtask

  task automatic model_commit();
    logic [31:0] off;
    if (n_wr && n_dst != 0) m_rf[n_dst] = n_val;
    if (n_alu) m_status = n_status;
    if (e_wr) begin
      off = e_addr - DATA_BASE;
      if (off < 32'd1024) m_dmem[off[9:2]] = e_wdata;
    end
    if (n_exc) begin m_epc = m_pc; m_cause = n_cause; end
    m_pc = n_pc;
  endtask

  task automatic check_state(input string where);
    check({where, "_pc"}, bus.insMemAddress, m_pc);
    for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", where, i), dut.regFile[i], m_rf[i]);
    check({where, "_status"}, {28'h0, dut.status}, {28'h0, m_status});
    check({where, "_epc"}, dut.epc, m_epc);
    check({where, "_cause"}, dut.cause, m_cause);
  endtask

  // Entered and left at a falling edge; checks the bus mid-cycle, the state after the edge.
  task automatic step();
    #1;
    model_exec(fetch(m_pc));
    check("fetch_pc", bus.insMemAddress, m_pc);
    check("ins_read", {31'h0, bus.insMemRead}, 32'd1);
    check("d_read", {31'h0, bus.dataMemRead}, {31'h0, e_rd});
    check("d_write", {31'h0, bus.dataMemWrite}, {31'h0, e_wr});
    if (e_rd || e_wr) check("d_addr", bus.dataMemAddress, e_addr);
    if (e_wr) check("d_wdata", bus.dataWriteValue, e_wdata);
    @(posedge clock);
    #1;
    model_commit();
    check_state("post");
    @(negedge clock);
  endtask

  // ---------------- random program generation ----------------
`ifdef SINGLE_CYCLE_EXCEPTIONS_EN
  localparam int N_RFN = 11;
  localparam logic [5:0] R_FNS [11] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
  localparam int N_IOP = 7;
  localparam logic [5:0] I_OPS [7] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
`else
  localparam int N_RFN = 13;
  localparam logic [5:0] R_FNS [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
  localparam int N_IOP = 8;
  localparam logic [5:0] I_OPS [8] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
`endif
  localparam logic [31:0] BAD_INS [4] = '{32'hFC00_0000, 32'h7000_0000, 32'h4000_0000, 32'h0000_003F};

  function automatic logic [4:0] pick_dst();
    int r;
    r = $urandom_range(0, 14);
    return (r < 8) ? 5'(r) : 5'(r + 1);
  endfunction

  function automatic logic [31:0] rand_ins(input int idx);
    logic [4:0] s, t, d; logic [15:0] imm; int k;
    s = 5'($urandom_range(0, 15)); t = 5'($urandom_range(0, 15)); d = pick_dst();
    imm = 16'($urandom); k = $urandom_range(0, 9);
    if (k == 8 && idx >= 195) k = 0;
`ifdef SINGLE_CYCLE_EXCEPTIONS_EN
    if (k == 9) k = 1;
`endif
    case (k)
      0, 1, 2: return {6'h00, s, t, d, 5'($urandom_range(0, 31)), R_FNS[$urandom_range(0, N_RFN - 1)]};
      3, 4, 5: return {I_OPS[$urandom_range(0, N_IOP - 1)], s, d, imm};
      6: return {6'h23, 5'd8, d, 16'($urandom_range(0, 63) * 4)};
      7: return {6'h2B, 5'd8, t, 16'($urandom_range(0, 63) * 4)};
      8: return {($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, s, t, 16'($urandom_range(0, 3))};
      default: return BAD_INS[$urandom_range(0, 3)];
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 512; i++) imem[i] = 32'h0;
    for (int i = 0; i < 256; i++) begin dmem[i] = 32'h0; m_dmem[i] = 32'h0; end
    imem[0]  = 32'h2409_0064; // addiu $9,$0,100
    imem[1]  = 32'h240A_00C8; // addiu $10,$0,200
    imem[2]  = 32'h012A_5820; // add $11,$9,$10
    imem[3]  = 32'h3C08_1001; // lui $8,0x1001
    imem[4]  = 32'h1129_0002; // beq $9,$9,+2
    imem[5]  = 32'h2414_0001; // skipped
    imem[6]  = 32'h2414_0002; // skipped
    imem[7]  = 32'hAD09_0004; // sw $9,4($8)
    imem[8]  = 32'h8D0C_0004; // lw $12,4($8)
    imem[9]  = 32'h1529_0002; // bne $9,$9,+2
    imem[10] = 32'h0C10_0010; // jal 0x00400040
    imem[11] = 32'h2400_0005; // addiu $0,$0,5
    imem[12] = 32'h3C0D_7FFF; // lui $13,0x7FFF
    imem[13] = 32'h35AD_FFFF; // ori $13,$13,0xFFFF
    imem[14] = 32'h21AE_0001; // addi $14,$13,1
    imem[15] = 32'h0810_0020; // j 0x00400080
    imem[16] = 32'h240F_0007; // addiu $15,$0,7
    imem[17] = 32'h03E0_0008; // jr $31

    resetN = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_ins_read", {31'h0, bus.insMemRead}, 32'd0);
    check("rst_d_write", {31'h0, bus.dataMemWrite}, 32'd0);
    check("rst_d_read", {31'h0, bus.dataMemRead}, 32'd0);
    check("rst_sp", dut.regFile[29], 32'h1001_03FC);
    check_state("reset");
    resetN = 1'b1;

    step(); step(); step();
    check("add_result", dut.regFile[11], 32'h0000_012C);
    check("pc_after_3", bus.insMemAddress, 32'h0040_000C);
    check("z_after_add", {31'h0, dut.status[1]}, 32'd0);
    check("v_after_add", {31'h0, dut.status[3]}, 32'd0);
    step(); step();
    check("beq_taken", bus.insMemAddress, 32'h0040_001C);
    step(); step();
    check("lw_value", dut.regFile[12], 32'h0000_0064);
    check("sw_mem", dmem[1], 32'h0000_0064);
    step();
    check("bne_not_taken", bus.insMemAddress, 32'h0040_0028);
    step();
    check("jal_link", dut.regFile[31], 32'h0040_002C);
    check("jal_target", bus.insMemAddress, 32'h0040_0040);
    step(); step();
    check("jr_return", bus.insMemAddress, 32'h0040_002C);
    step();
    check("zero_reg", dut.regFile[0], 32'h0);
    step(); step(); step();
`ifdef SINGLE_CYCLE_EXCEPTIONS_EN
    check("ovf_epc", dut.epc, 32'h0040_0038);
    check("ovf_cause", dut.cause, 32'h30);
    check("ovf_no_write", dut.regFile[14], 32'h0);
    check("ovf_vector", bus.insMemAddress, 32'h8000_0180);
`else
    check("ovf_wrap", dut.regFile[14], 32'h8000_0000);
    check("ovf_v_flag", {31'h0, dut.status[3]}, 32'd1);
    check("ovf_pc", bus.insMemAddress, 32'h0040_003C);
`endif
    step();

    // Asynchronous reset between edges, then a random program from the text base.
    @(posedge clock);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check("mid_rst_pc", bus.insMemAddress, 32'h0040_0000);
    check("mid_rst_d_write", {31'h0, bus.dataMemWrite}, 32'd0);
    check_state("mid_reset");
    for (int i = 0; i < 512; i++) imem[i] = 32'h0;
    imem[0] = 32'h3C08_1001; // lui $8,0x1001
    for (int i = 1; i <= 200; i++) imem[i] = rand_ins(i);
    imem[201] = 32'h0810_0001; // j 0x00400004
    @(negedge clock);
    resetN = 1'b1;
    repeat (600) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/single_cycle_data_path.md
# single_cycle_data_path

Single-cycle MIPS32 integer datapath: fetches, decodes, executes and retires one instruction per clock. It connects to separate external instruction and data memories. Program text is based at 0x00400000 and data at 0x10010000. It holds the PC, a 32×32 register file, an ALU status register (V/N/Z/C), and the exception registers EPC and Cause.

## Interface
- No parameters.
- clock  in  1  rising-edge clock; all state commits on posedge.
- resetN  in  1  asynchronous, active-low reset.
- insReadValue  in  32  instruction word at insMemAddress (combinational memory).
- dataReadValue  in  32  data word at dataMemAddress (combinational memory).
- insMemAddress  out  32  byte address of fetch; equals pc.
- insMemRead  out  1  fetch enable; constant 1 when resetN=1, 0 in reset.
- dataMemAddress  out  32  byte address for lw/sw; equals aluOut (rs + signext(imm)).
- dataMemRead  out  1  high only while executing lw.
- dataMemWrite  out  1  high only while executing sw; memory writes on posedge clock.
- dataWriteValue  out  32  rf[rt] during sw.

## Operation
- Decode fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shiftAmount[10:6], funct[5:0], immediate[15:0], jumpAddress[25:0].
- R-type (opcode 0) functs: add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B, sll 00, srl 02, sra 03, jr 08. The result goes to rd.
- I-type: addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lui 0F, lw 23, sw 2B, beq 04, bne 05.
- Immediates are sign-extended for arithmetic, slt*, and lw/sw, and zero-extended for andi/ori/xori. lui writes {imm,16'h0}. The result goes to rt.
- J-type: j 02, jal 03. jal writes $31 = pc+4.
- Next PC:
  - Default: pc+4.
  - Taken branch: pc+4+(signext(imm)<<2).
  - j/jal: {pc+4[31:28], jumpAddress, 2'b00}.
  - jr: rf[rs].
- Register 0 reads as 0. Writes to register 0 are discarded.
- Status register: nextStatus = {V,N,Z,C} from the ALU.
  - Loaded only on R-type ALU ops and I-type ALU ops. Loads, stores, branches and jumps leave it unchanged.
  - N = aluOut[31]; Z = (aluOut==0).
  - C = carry-out of the 33-bit add. For subtraction, C = 1 when no borrow occurs (rs ≥ operand, unsigned).
  - V = signed overflow for add/sub forms; 0 for all other ops.
- Exceptions (when enabled, see Configuration):
  - Overflow on add/sub/addi: Cause ExcCode 12, so nextCause = 0x30.
  - Unknown opcode or funct: ExcCode 10, so nextCause = 0x28.
  - On an exception: EPC ← pc, Cause ← nextCause, pc ← 0x80000180, and there is no register or memory write.

## Timing
- Fetch, decode, ALU, data read and next-PC calculation are purely combinational within one cycle. The CPI is 1.
- At posedge clock the block updates pc, the rf write, status, EPC and Cause. The sw write commits externally on the same edge.
- lw data must be valid in the same cycle. The register write from lw occurs at the cycle's closing edge.
- Reset (asynchronous, any time, including mid-instruction) forces:
  - pc = 0x00400000.
  - All registers = 0, except $sp (29) = 0x100103FC.
  - status = 0, EPC = 0, Cause = 0.
  - dataMemRead = dataMemWrite = 0.
- The first fetch occurs on the first posedge after resetN rises. No partial writes survive a reset.

## Configuration
- SINGLE_CYCLE_EXCEPTIONS_EN defined: overflow and reserved-instruction traps operate as described above.
- SINGLE_CYCLE_EXCEPTIONS_EN undefined:
  - add/sub/addi behave as addu/subu/addiu, but V is still computed.
  - Unknown instructions are no-ops that advance pc by 4.
  - EPC and Cause remain 0.

## Test plan
- ALU sequence: 0x24090064, 0x240a00c8, 0x012a5820 (addiu $9,$0,100; addiu $10,$0,200; add $11,$9,$10) -> after 3 clocks $9=0x64, $10=0xC8, $11=0x12C, pc=0x0040000C, Z=0, V=0.
- Memory: sw $9,4($0+0x10010000 base in $8), then lw $12,4($8) -> dataMemWrite pulse with addr 0x10010004 and data 0x64; $12=0x64.
- Control flow:
  - beq with equal registers and imm=2 at pc 0x00400010 -> pc 0x0040001C.
  - bne with the same operands is not taken -> pc+4.
  - jal 0x00400040 -> $ra = pc+4.
  - jr $ra returns to that address.
- Overflow: lui $8,0x7FFF; ori $8,$8,0xFFFF; addi $9,$8,1 at pc P -> with the macro defined, EPC=P, Cause=0x30, $9 unchanged, pc=0x80000180. Without the macro, $9=0x80000000 and V=1.
- Reset mid-run: assert resetN=0 between edges -> pc=0x00400000 immediately, registers 0, $sp=0x100103FC, no dataMemWrite. Resuming re-executes from 0x00400000.
- $zero: addiu $0,$0,5 -> $0 remains 0.
